// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_detect_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2,
      EDGE_BOTH = 2'd3
   } edge_mode_t;

   // Enough bits to hold FILTER_LEN (the counter never exceeds FILTER_LEN-1).
   function automatic int cnt_width(input int filter_len);
      return $clog2(filter_len + 1);
   endfunction

endpackage

// File: rtl/edge_detect_filt_chan.sv
// One channel: synchroniser chain, debounce filter and registered rise/fall pulses.
module edge_detect_filt_chan
   import edge_detect_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_LEN  = 4,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_raw,
   output logic level,
   output logic rising,
   output logic falling,
   output logic rise_nxt,
   output logic fall_nxt
);

   localparam int            CW      = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rising_q, falling_q;
   logic                   s;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A level is accepted only after FILTER_LEN consecutive disagreeing samples;
   // any agreement in between restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_nxt = level_d & ~level_q;
   assign fall_nxt = ~level_d & level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
         cnt_q     <= '0;
         level_q   <= RESET_LEVEL;
         rising_q  <= 1'b0;
         falling_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         rising_q  <= rise_nxt;
         falling_q <= fall_nxt;
      end
   end

   assign level   = level_q;
   assign rising  = rising_q;
   assign falling = falling_q;

endmodule

// File: rtl/edge_detect_filt.sv
// Multi-channel filtered edge detector with per-channel mode select and sticky IRQ latches.
module edge_detect_filt
   import edge_detect_pkg::*;
#(
   parameter int   WIDTH       = 16,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_LEN  = 4,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in,
   input  logic [2*WIDTH-1:0]   mode,
   input  logic [WIDTH-1:0]     clr,
   output logic [WIDTH-1:0]     level,
   output logic [WIDTH-1:0]     rising,
   output logic [WIDTH-1:0]     falling,
   output logic [WIDTH-1:0]     both,
   // `event` is a reserved word, so the mode-qualified pulse is named evt.
   output logic [WIDTH-1:0]     evt,
   output logic [WIDTH-1:0]     pending,
   output logic [WIDTH-1:0]     overflow,
   output logic                 irq
);

   logic [WIDTH-1:0] rise_nxt, fall_nxt;
   logic [WIDTH-1:0] evt_q, evt_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] overflow_q, overflow_d;
   logic             irq_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      edge_detect_filt_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .RESET_LEVEL (RESET_LEVEL)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .in_raw   (in[g]),
         .level    (level[g]),
         .rising   (rising[g]),
         .falling  (falling[g]),
         .rise_nxt (rise_nxt[g]),
         .fall_nxt (fall_nxt[g])
      );
   end

   function automatic logic qualify(input edge_mode_t m, input logic r, input logic f);
      logic q;
      q = 1'b0;
      case (m)
         EDGE_OFF:  q = 1'b0;
         EDGE_RISE: q = r;
         EDGE_FALL: q = f;
         EDGE_BOTH: q = r | f;
      endcase
      return q;
   endfunction

   // The latches act on the visible evt pulse, so a clear issued while evt is
   // high can never swallow that event.
   always_comb begin
      evt_d      = '0;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      for (int i = 0; i < WIDTH; i++) begin
         evt_d[i] = qualify(edge_mode_t'(mode[2*i +: 2]), rise_nxt[i], fall_nxt[i]);
         if (evt_q[i] && pending_q[i] && !clr[i]) begin
            overflow_d[i] = 1'b1;
         end else if (clr[i] && evt_q[i]) begin
            pending_d[i]  = 1'b1;
            overflow_d[i] = 1'b0;
         end else if (clr[i]) begin
            pending_d[i]  = 1'b0;
            overflow_d[i] = 1'b0;
         end else if (evt_q[i]) begin
            pending_d[i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_q      <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         evt_q      <= evt_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         irq_q      <= |pending_d;
      end
   end

   assign both     = rising | falling;
   assign evt      = evt_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_edge_detect_filt.sv
// Directed, table-driven bench for edge_detect_filt plus a second instance with minimal latency.
module tb_edge_detect_filt;
   import edge_detect_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_a, clr_a;
   logic [7:0] mode_a;
   logic [3:0] level_a, rising_a, falling_a, both_a, evt_a, pending_a, overflow_a;
   logic       irq_a;
   logic [3:0] in_b, clr_b;
   logic [7:0] mode_b;
   logic [3:0] level_b, rising_b, falling_b, both_b, evt_b, pending_b, overflow_b;
   logic       irq_b;

   int assert_count = 0;
   int fail_count   = 0;

   always #5 clk = ~clk;

   edge_detect_filt #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3), .RESET_LEVEL(1'b0)) dut (
      .clk(clk), .rst(rst), .in(in_a), .mode(mode_a), .clr(clr_a),
      .level(level_a), .rising(rising_a), .falling(falling_a), .both(both_a),
      .evt(evt_a), .pending(pending_a), .overflow(overflow_a), .irq(irq_a)
   );

   edge_detect_filt #(.WIDTH(4), .SYNC_STAGES(1), .FILTER_LEN(1), .RESET_LEVEL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in(in_b), .mode(mode_b), .clr(clr_b),
      .level(level_b), .rising(rising_b), .falling(falling_b), .both(both_b),
      .evt(evt_b), .pending(pending_b), .overflow(overflow_b), .irq(irq_b)
   );

   typedef struct {
      logic       rst;
      logic [3:0] in;
      logic [7:0] mode;
      logic [3:0] clr;
      logic [3:0] level, rising, falling, evt, pending, overflow;
      logic       irq;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic r, input logic [3:0] i, input logic [7:0] m,
                                   input logic [3:0] c, input logic [3:0] lv, input logic [3:0] ri,
                                   input logic [3:0] fa, input logic [3:0] ev, input logic [3:0] pe,
                                   input logic [3:0] ov, input logic iq);
      vec_t v;
      v.rst = r; v.in = i; v.mode = m; v.clr = c;
      v.level = lv; v.rising = ri; v.falling = fa; v.evt = ev;
      v.pending = pe; v.overflow = ov; v.irq = iq;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic r, input logic [3:0] i, input logic [7:0] m,
                                input logic [3:0] c);
      rst = r; in_a = i; mode_a = m; clr_a = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic check_a(input string tag, input logic [3:0] lv, input logic [3:0] ri,
                          input logic [3:0] fa, input logic [3:0] ev, input logic [3:0] pe,
                          input logic [3:0] ov, input logic iq);
      checkOutput({tag, " level"},    level_a,    lv);
      checkOutput({tag, " rising"},   rising_a,   ri);
      checkOutput({tag, " falling"},  falling_a,  fa);
      checkOutput({tag, " both"},     both_a,     ri | fa);
      checkOutput({tag, " evt"},      evt_a,      ev);
      checkOutput({tag, " pending"},  pending_a,  pe);
      checkOutput({tag, " overflow"}, overflow_a, ov);
      checkOutput({tag, " irq"},      {3'b000, irq_a}, {3'b000, iq});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; in_a = 4'h0; mode_a = 8'h00; clr_a = 4'h0;
      in_b = 4'hF; mode_b = 8'h02; clr_b = 4'h0;

      // Reset release with all inputs high, then glitch rejection and a clean pulse on ch0.
      add_vec(1, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(1, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 4; i++)
         add_vec(0, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'hF, 8'h00, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'hF, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(1, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 2; i++)
         add_vec(0, 4'h1, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 4; i++)
         add_vec(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 3; i++)
         add_vec(0, 4'h1, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      // ch1 in EDGE_FALL mode: only the falling pulse raises evt and pending.
      for (int i = 0; i < 4; i++)
         add_vec(0, 4'h2, 8'h08, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h2, 8'h08, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 5; i++)
         add_vec(0, 4'h2, 8'h08, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 4; i++)
         add_vec(0, 4'h0, 8'h08, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h08, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 0);
      add_vec(0, 4'h0, 8'h08, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1);
      add_vec(0, 4'h0, 8'h08, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1);

      foreach (vecs[n]) begin
         applyStimulus(vecs[n].rst, vecs[n].in, vecs[n].mode, vecs[n].clr);
         check_a($sformatf("vec%0d", n), vecs[n].level, vecs[n].rising, vecs[n].falling,
                 vecs[n].evt, vecs[n].pending, vecs[n].overflow, vecs[n].irq);
      end

      // Overflow and clear priority on ch2 with every channel in EDGE_BOTH.
      applyStimulus(1, 4'h0, 8'hFF, 4'h0);
      check_a("ovf reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'h4, 8'hFF, 4'h0);
      check_a("ovf rise1", 4'h4, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 0);
      applyStimulus(0, 4'h4, 8'hFF, 4'h0);
      check_a("ovf pend1", 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'h0, 8'hFF, 4'h0);
      check_a("ovf fall2", 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 1);
      applyStimulus(0, 4'h0, 8'hFF, 4'h0);
      check_a("ovf set", 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'h4, 8'hFF, 4'h0);
      check_a("ovf rise3", 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 1);
      applyStimulus(0, 4'h4, 8'hFF, 4'h4);
      check_a("clr with evt", 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1);
      applyStimulus(0, 4'h4, 8'hFF, 4'h4);
      check_a("clr alone", 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      applyStimulus(0, 4'h4, 8'hFF, 4'h0);
      check_a("clr idle", 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

      // Mid-operation reset on ch3 with a partial count in flight.
      applyStimulus(1, 4'h0, 8'hFF, 4'h0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'h8, 8'hFF, 4'h0);
      applyStimulus(0, 4'h8, 8'hFF, 4'h0);
      check_a("mid pend", 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'h0, 8'hFF, 4'h0);
      applyStimulus(0, 4'h0, 8'hFF, 4'h0);
      check_a("mid low", 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 4'h8, 8'hFF, 4'h0);
      check_a("mid partial", 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 1);
      applyStimulus(1, 4'h8, 8'hFF, 4'h0);
      check_a("mid rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 4'h8, 8'hFF, 4'h0);
         check_a($sformatf("requal %0d", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      end
      applyStimulus(0, 4'h8, 8'hFF, 4'h0);
      check_a("requal 5", 4'h8, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 0);

      // Minimal-latency instance, reset level high: in[0] falls.
      in_b = 4'hF;
      applyStimulus(1, 4'h0, 8'h00, 4'h0);
      checkOutput("b reset level",   level_b,   4'hF);
      checkOutput("b reset rising",  rising_b,  4'h0);
      checkOutput("b reset falling", falling_b, 4'h0);
      applyStimulus(0, 4'h0, 8'h00, 4'h0);
      checkOutput("b idle falling", falling_b, 4'h0);
      checkOutput("b idle level",   level_b,   4'hF);
      in_b = 4'hE;
      applyStimulus(0, 4'h0, 8'h00, 4'h0);
      checkOutput("b k falling", falling_b, 4'h0);
      checkOutput("b k level",   level_b,   4'hF);
      applyStimulus(0, 4'h0, 8'h00, 4'h0);
      checkOutput("b k+1 falling", falling_b, 4'h1);
      checkOutput("b k+1 level",   level_b,   4'hE);
      checkOutput("b k+1 evt",     evt_b,     4'h1);
      applyStimulus(0, 4'h0, 8'h00, 4'h0);
      checkOutput("b after falling", falling_b, 4'h0);
      checkOutput("b pending",       pending_b, 4'h1);
      checkOutput("b irq",           {3'b000, irq_b}, 4'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
